// File: rtl/fir_interp_if.sv
// Sample, coefficient-ROM and status bundle for the x2 polyphase FIR interpolator.
// The slave modport is the filter; the master side is the baseband source, the ROM and the consumer.
interface fir_interp_if #(
  parameter int TAPS      = 256,
  parameter int OUT_WIDTH = 32
);
  localparam int ADDR_W = $clog2(TAPS);

  logic                        in_strobe;
  logic signed [23:0]          in_data;
  logic        [ADDR_W-1:0]    coeff_addr;
  logic signed [23:0]          coeff;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_strobe;
  logic                        busy;
  logic                        overrun;

  modport master (
    output in_strobe, in_data, coeff,
    input  coeff_addr, out_data, out_strobe, busy, overrun
  );

  modport slave (
    input  in_strobe, in_data, coeff,
    output coeff_addr, out_data, out_strobe, busy, overrun
  );
endinterface

// File: rtl/fir_interp.sv
// TX x2 polyphase FIR interpolator: one input sample yields two outputs from a serial MAC.
// Define FIR_INTERP_SAT_EN to saturate the rounded output instead of wrapping it.
module fir_interp #(
  parameter int TAPS      = 256,
  parameter int OUT_WIDTH = 32,
  parameter int MSB       = 46
) (
  input logic           clock,
  input logic           reset_n,
  fir_interp_if.slave   bus
);
  localparam int HALF   = TAPS / 2;
  localparam int ADDR_W = $clog2(TAPS);
  localparam int PTR_W  = ADDR_W - 1;
  localparam int PROD_W = 48;
  localparam int ACC_W  = 56;
  localparam int LSB    = MSB - OUT_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, MAC0, FLUSH0, OUT0, MAC1, FLUSH1, OUT1
  } state_t;

  state_t state, next_state;

  logic signed [23:0]          sample_q;
  logic signed [23:0]          hist [HALF];
  logic        [PTR_W-1:0]     wr_ptr;
  logic        [PTR_W-1:0]     rd_idx;
  logic        [PTR_W-1:0]     tap;
  logic        [ADDR_W-1:0]    fill;
  logic        [1:0]           flush_cnt;
  logic signed [23:0]          hist_q;
  logic signed [23:0]          mult_a;
  logic signed [23:0]          mult_b;
  logic signed [PROD_W-1:0]    prod;
  logic                        v1, v2, v3;
  logic signed [ACC_W-1:0]     acc;
  logic signed [ACC_W-1:0]     acc_next;
  logic signed [OUT_WIDTH-1:0] out_rounded;
  logic                        issuing;
  logic                        last_tap;
  logic                        flush_done;

  // The tap index lives in the upper address bits; bit 0 is the polyphase select.
  assign tap        = bus.coeff_addr[ADDR_W-1:1];
  assign rd_idx     = wr_ptr - PTR_W'(1) - tap;
  assign issuing    = (state == MAC0) || (state == MAC1);
  assign last_tap   = (tap == PTR_W'(HALF - 1));
  assign flush_done = ((state == FLUSH0) || (state == FLUSH1)) && (flush_cnt == 2'd2);
  assign acc_next   = v3 ? acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod} : acc;

`ifdef FIR_INTERP_SAT_EN
  localparam int SC_W = ACC_W - LSB + 1;
  logic signed [SC_W-1:0] scaled;

  // One guard bit above the accumulator catches the rounding carry as well as true overflow.
  assign scaled = {acc_next[ACC_W-1], acc_next[ACC_W-1:LSB]} + SC_W'(acc_next[LSB-1]);

  always_comb begin
    out_rounded = scaled[OUT_WIDTH-1:0];
    if (!((&scaled[SC_W-1:OUT_WIDTH-1]) || (~|scaled[SC_W-1:OUT_WIDTH-1]))) begin
      if (scaled[SC_W-1])
        out_rounded = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      else
        out_rounded = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  assign out_rounded = acc_next[MSB:LSB] + OUT_WIDTH'(acc_next[LSB-1]);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.in_strobe) next_state = LOAD;
      LOAD:    next_state = MAC0;
      MAC0:    if (last_tap) next_state = FLUSH0;
      FLUSH0:  if (flush_done) next_state = OUT0;
      OUT0:    next_state = MAC1;
      MAC1:    if (last_tap) next_state = FLUSH1;
      FLUSH1:  if (flush_done) next_state = OUT1;
      OUT1:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // History RAM has no reset; the fill counter masks entries not yet written.
  always_ff @(posedge clock) begin
    if (state == LOAD) hist[wr_ptr] <= sample_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_q       <= '0;
      wr_ptr         <= '0;
      fill           <= '0;
      flush_cnt      <= '0;
      bus.coeff_addr <= '0;
    end else begin
      if (state == IDLE && bus.in_strobe) sample_q <= bus.in_data;
      if (state == LOAD) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != ADDR_W'(HALF)) fill <= fill + 1'b1;
      end
      if (state == FLUSH0 || state == FLUSH1) flush_cnt <= flush_cnt + 1'b1;
      else                                    flush_cnt <= '0;
      case (state)
        LOAD:       bus.coeff_addr <= '0;
        MAC0, MAC1: if (!last_tap) bus.coeff_addr <= bus.coeff_addr + ADDR_W'(2);
        OUT0:       bus.coeff_addr <= ADDR_W'(1);
        OUT1:       bus.coeff_addr <= '0;
        default:    ;
      endcase
    end
  end

  // ROM and history read line up one clock after the address; the multiplier adds two more.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      hist_q <= '0;
      mult_a <= '0;
      mult_b <= '0;
      prod   <= '0;
      acc    <= '0;
    end else begin
      v1     <= issuing;
      v2     <= v1;
      v3     <= v2;
      hist_q <= ({1'b0, tap} < fill) ? hist[rd_idx] : '0;
      mult_a <= bus.coeff;
      mult_b <= hist_q;
      prod   <= PROD_W'(mult_a) * PROD_W'(mult_b);
      if (state == LOAD || state == OUT0 || state == OUT1) acc <= '0;
      else                                                 acc <= acc_next;
    end
  end

  // The last product lands in the final flush cycle, so the output takes acc_next directly.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_data   <= '0;
      bus.out_strobe <= 1'b0;
      bus.busy       <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      if (flush_done) bus.out_data <= out_rounded;
      bus.out_strobe <= (next_state == OUT0) || (next_state == OUT1);
      bus.busy       <= (next_state != IDLE);
      bus.overrun    <= bus.overrun | (bus.in_strobe & bus.busy);
    end
  end
endmodule
